// File: rtl/channel_strategy_pkg.sv
// rtl/channel_strategy_pkg.sv - shared types for the per-channel strategy block
package channel_strategy_pkg;

    localparam int MODE_W = 3;

    // Encodings 6 and 7 are reserved: such a channel outputs 0 and keeps its state cleared.
    typedef enum logic [MODE_W-1:0] {
        MODE_NOP     = 3'd0,
        MODE_XOR     = 3'd1,
        MODE_INV     = 3'd2,
        MODE_DELAY   = 3'd3,
        MODE_STRETCH = 3'd4,
        MODE_EDGE    = 3'd5
    } strategy_mode_t;

    function automatic logic mode_is_reserved(input logic [MODE_W-1:0] mode);
        return mode > MODE_EDGE;
    endfunction

endpackage

// File: rtl/channel_strategy_channel.sv
// rtl/channel_strategy_channel.sv - one channel: config regs, delay line, stretch counter, edge history
module strategy_channel
    import channel_strategy_pkg::*;
#(
    parameter int DLY_W = 4,
    parameter int LEN_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              x,
    input  logic [MODE_W-1:0] mode_in,
    input  logic [LEN_W-1:0]  arg_in,
    input  logic              cfg_load,
    output logic              out_q,
    output logic              active_q
);

    localparam int DEPTH = (2 ** DLY_W) - 1;

    logic [MODE_W-1:0] mode_q;
    logic [LEN_W-1:0]  arg_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [DEPTH-1:0]  dly_q;
    logic              prev_q;

    logic [DLY_W-1:0]  dsel;
    logic              tap;
    logic              rise;
    logic [LEN_W-1:0]  stretch_len;
    logic [LEN_W-1:0]  cnt_next;
    logic              out_next;
    logic              mode_change;
    logic              reserved;

    // Next-state and next-output for the currently active config (old config still applies on a load edge).
    always_comb begin
        dsel        = arg_q[DLY_W-1:0];
        tap         = x;
        if (dsel != '0) begin
            // dly_q[k] holds the input sampled k+1 cycles ago, so a delay of d reads entry d-1.
            tap = dly_q[dsel - DLY_W'(1)];
        end
        rise        = x & ~prev_q;
        stretch_len = (arg_q == '0) ? LEN_W'(1) : arg_q;
        cnt_next    = '0;
        if (mode_q == MODE_STRETCH) begin
            if (rise) begin
                cnt_next = stretch_len;
            end else if (cnt_q != '0) begin
                cnt_next = cnt_q - LEN_W'(1);
            end
        end
        out_next = 1'b0;
        case (mode_q)
            MODE_NOP:     out_next = x;
            MODE_XOR:     out_next = x ^ arg_q[0];
            MODE_INV:     out_next = ~x;
            MODE_DELAY:   out_next = tap;
            MODE_STRETCH: out_next = (cnt_next != '0);
            MODE_EDGE:    out_next = rise;
            default:      out_next = 1'b0;
        endcase
        mode_change = cfg_load && (mode_in != mode_q);
        reserved    = mode_is_reserved(mode_q);
    end

    // Channel state: a mode change (or a reserved mode) wipes history; an arg-only change keeps it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q   <= MODE_NOP;
            arg_q    <= '0;
            cnt_q    <= '0;
            dly_q    <= '0;
            prev_q   <= 1'b0;
            out_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            out_q    <= out_next;
            active_q <= (mode_q == MODE_STRETCH) && (cnt_next != '0);
            if (mode_change || reserved) begin
                dly_q  <= '0;
                cnt_q  <= '0;
                prev_q <= 1'b0;
            end else begin
                dly_q  <= {dly_q[DEPTH-2:0], x};
                cnt_q  <= cnt_next;
                prev_q <= x;
            end
            if (cfg_load) begin
                mode_q <= mode_in;
                arg_q  <= arg_in;
            end
        end
    end

endmodule

// File: rtl/channel_strategy.sv
// rtl/channel_strategy.sv - N_CH independent strategy channels with atomically loaded config
module channel_strategy
    import channel_strategy_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int DLY_W = 4,
    parameter int LEN_W = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_CH-1:0]         in_sig,
    input  logic [N_CH*MODE_W-1:0]  mode_i,
    input  logic [N_CH*LEN_W-1:0]   arg_i,
    input  logic                    cfg_load,
    output logic                    cfg_ack,
    output logic [N_CH-1:0]         out_sig,
    output logic [N_CH-1:0]         active
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        strategy_channel #(
            .DLY_W (DLY_W),
            .LEN_W (LEN_W)
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .x        (in_sig[i]),
            .mode_in  (mode_i[MODE_W*i +: MODE_W]),
            .arg_in   (arg_i[LEN_W*i +: LEN_W]),
            .cfg_load (cfg_load),
            .out_q    (out_sig[i]),
            .active_q (active[i])
        );
    end

    // Acknowledge each sampled load strobe one cycle later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cfg_ack <= 1'b0;
        end else begin
            cfg_ack <= cfg_load;
        end
    end

endmodule

// File: tb/tb_channel_strategy.sv
// tb/tb_channel_strategy.sv - scoreboard bench for channel_strategy
module tb_channel_strategy;

    localparam int N  = 8;
    localparam int LW = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    in_sig = '0;
    logic [N*3-1:0]  mode_i = '0;
    logic [N*LW-1:0] arg_i = '0;
    logic            cfg_load = 1'b0;
    logic            cfg_ack;
    logic [N-1:0]    out_sig;
    logic [N-1:0]    active;

    channel_strategy #(.N_CH(N), .DLY_W(4), .LEN_W(LW)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_sig   (in_sig),
        .mode_i   (mode_i),
        .arg_i    (arg_i),
        .cfg_load (cfg_load),
        .cfg_ack  (cfg_ack),
        .out_sig  (out_sig),
        .active   (active)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [N-1:0] out;
        logic [N-1:0] act;
        logic         ack;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: mode/arg per channel, input history since last clear (newest first),
    // and for stretch the age of the last rising edge plus the length captured at that edge.
    int m_mode[N];
    int m_arg[N];
    bit m_hist[N][$];
    int m_age[N];
    int m_len[N];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_mode[i] = 0;
            m_arg[i]  = 0;
            m_hist[i].delete();
            m_age[i]  = 0;
            m_len[i]  = 0;
        end
    endfunction

    function automatic exp_t model_step();
        exp_t e;
        e.out = '0;
        e.act = '0;
        e.ack = cfg_load;
        for (int i = 0; i < N; i++) begin
            bit x;
            bit prev;
            bit o;
            int d;
            int len;
            int nm;
            x    = in_sig[i];
            prev = (m_hist[i].size() > 0) ? m_hist[i][0] : 1'b0;
            d    = m_arg[i] % 16;
            len  = (m_arg[i] == 0) ? 1 : m_arg[i];
            o    = 1'b0;
            case (m_mode[i])
                0: o = x;
                1: o = x ^ ((m_arg[i] % 2) == 1);
                2: o = !x;
                3: o = (d == 0) ? x : ((m_hist[i].size() >= d) ? m_hist[i][d-1] : 1'b0);
                4: begin
                    if (x && !prev) begin
                        m_age[i] = 0;
                        m_len[i] = len;
                    end else if (m_age[i] < 1000) begin
                        m_age[i]++;
                    end
                    o = (m_age[i] < m_len[i]);
                end
                5: o = x && !prev;
                default: o = 1'b0;
            endcase
            e.out[i] = o;
            e.act[i] = (m_mode[i] == 4) && o;
            if (m_mode[i] > 5) begin
                m_hist[i].delete();
            end else begin
                m_hist[i].push_front(x);
                if (m_hist[i].size() > 15) void'(m_hist[i].pop_back());
            end
            if (m_mode[i] != 4) begin
                m_age[i] = 0;
                m_len[i] = 0;
            end
            if (cfg_load) begin
                nm = int'(mode_i[3*i +: 3]);
                if (nm != m_mode[i]) begin
                    m_hist[i].delete();
                    m_age[i] = 0;
                    m_len[i] = 0;
                end
                m_mode[i] = nm;
                m_arg[i]  = int'(arg_i[LW*i +: LW]);
            end
        end
        return e;
    endfunction

    // Called at a falling edge with inputs already driven: predict the next rising edge.
    task automatic tick();
        sb.push_back(model_step());
        @(negedge clock);
    endtask

    task automatic set_ch(input int ch, input int m, input int a);
        mode_i[3*ch +: 3]   = 3'(m);
        arg_i[LW*ch +: LW]  = LW'(a);
    endtask

    task automatic load();
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Monitor: compare each registered output against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (reset === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_sig", 32'(out_sig), 32'(e.out));
                chk("active", 32'(active), 32'(e.act));
                chk("cfg_ack", 32'(cfg_ack), 32'(e.ack));
            end
        end
    end

    initial begin
        model_reset();
        in_sig = 8'hA5;
        repeat (3) @(negedge clock);
        chk("reset_out", 32'(out_sig), 32'h0);
        chk("reset_active", 32'(active), 32'h0);
        chk("reset_ack", 32'(cfg_ack), 32'h0);
        reset = 1'b1;
        in_sig = 8'hA5;
        tick();
        in_sig = 8'h3C;
        tick();
        in_sig = 8'h00;
        tick();

        // Delay of 5 on ch0, single pulse, then delay 0 behaves as NOP.
        set_ch(0, 3, 5);
        load();
        idle(2);
        in_sig[0] = 1'b1;
        tick();
        in_sig[0] = 1'b0;
        idle(10);
        set_ch(0, 3, 16'h50);
        load();
        for (int k = 0; k < 8; k++) begin
            in_sig[0] = 1'($urandom);
            tick();
        end
        in_sig = '0;

        // Stretch 4 on ch1 with retrigger, then L=0.
        set_ch(1, 4, 4);
        load();
        in_sig[1] = 1'b1; tick();
        in_sig[1] = 1'b0; tick();
        in_sig[1] = 1'b1; tick();
        in_sig[1] = 1'b0; idle(7);
        set_ch(1, 4, 0);
        load();
        in_sig[1] = 1'b1; tick();
        in_sig[1] = 1'b0; idle(3);
        in_sig[1] = 1'b1; idle(4);
        in_sig[1] = 1'b0; idle(2);

        // Edge on ch2 with a long high level; XOR then INV on ch3.
        set_ch(2, 5, 0);
        set_ch(3, 1, 1);
        load();
        in_sig[2] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_sig[3] = 1'($urandom);
            tick();
        end
        in_sig[2] = 1'b0;
        set_ch(3, 2, 0);
        load();
        for (int k = 0; k < 8; k++) begin
            in_sig[3] = 1'($urandom);
            tick();
        end

        // Mode change DELAY->NOP with a pulse still inside the delay line.
        set_ch(0, 3, 5);
        load();
        in_sig[0] = 1'b1; tick();
        in_sig[0] = 1'b0; idle(2);
        set_ch(0, 0, 0);
        load();
        idle(8);

        // Reset in the middle of a stretch pulse.
        set_ch(1, 4, 6);
        load();
        in_sig[1] = 1'b1; tick();
        in_sig[1] = 1'b0; idle(3);
        #1 reset = 1'b0;
        #1;
        chk("midreset_out", 32'(out_sig), 32'h0);
        chk("midreset_active", 32'(active), 32'h0);
        sb.delete();
        model_reset();
        mode_i = '0;
        arg_i = '0;
        in_sig = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        idle(8);

        // Randomised traffic with occasional reconfiguration.
        for (int k = 0; k < 600; k++) begin
            in_sig = N'($urandom);
            cfg_load = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                for (int c = 0; c < N; c++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        set_ch(c, $urandom_range(0, 7),
                               ($urandom_range(0, 1) == 1) ? $urandom_range(0, 255) : $urandom_range(0, 6));
                    end
                end
                cfg_load = 1'b1;
            end
            tick();
        end
        cfg_load = 1'b0;
        in_sig = '0;
        @(posedge clock);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
